// File: rtl/alu_seq_n.sv
// Registered ALU with start/busy/done handshake and a shift-add unsigned multiplier.
// Optional zero/ovf status outputs are enabled by defining ALU_STATUS_FLAGS_EN.
module alu_seq_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             c_o
`ifdef ALU_STATUS_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpXor = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpSlt = 3'b100;
  localparam logic [2:0] OpNor = 3'b101;
  localparam logic [2:0] OpAnd = 3'b110;
  localparam logic [2:0] OpOr  = 3'b111;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  // Upper half accumulates partial sums, lower half holds the unconsumed multiplier bits.
  logic [2*WIDTH-1:0]   prod_q;

  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_sum;
  logic [WIDTH-1:0]     res_d;
  logic                 carry_d;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_nxt;
`ifdef ALU_STATUS_FLAGS_EN
  logic                 ovf_d;
`endif

  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_i};
    sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    res_d   = '0;
    carry_d = 1'b0;
    unique case (op)
      OpAdd: {carry_d, res_d} = add_sum;
      OpSub: {carry_d, res_d} = sub_sum;
      OpXor: res_d = a ^ b;
      OpSlt: res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpNor: res_d = ~(a | b);
      OpAnd: res_d = a & b;
      OpOr:  res_d = a | b;
      OpMul: res_d = '0;
    endcase
  end

`ifdef ALU_STATUS_FLAGS_EN
  always_comb begin
    ovf_d = 1'b0;
    if (op == OpAdd) begin
      ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    end else if (op == OpSub) begin
      ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
    end
  end
`endif

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= '0;
      r_hi    <= '0;
      c_o     <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
      zero    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (op == OpMul) begin
              state_q <= StMul;
              busy    <= 1'b1;
              cnt_q   <= '0;
              mcand_q <= a;
              prod_q  <= {{WIDTH{1'b0}}, b};
            end else begin
              r    <= res_d;
              r_hi <= '0;
              c_o  <= carry_d;
              done <= 1'b1;
`ifdef ALU_STATUS_FLAGS_EN
              zero <= (res_d == '0);
              ovf  <= ovf_d;
`endif
            end
          end
        end
        StMul: begin
          prod_q <= prod_nxt;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
            r       <= prod_nxt[WIDTH-1:0];
            r_hi    <= prod_nxt[2*WIDTH-1:WIDTH];
            c_o     <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
            zero    <= (prod_nxt == '0);
            ovf     <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n: per-cycle comparison against a behavioural model
// plus directed vectors with hand-computed results.
module tb_alu_seq_n;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_i = 1'b0;
  logic         busy, done, c_o;
  logic [W-1:0] r, r_hi;
`ifdef ALU_STATUS_FLAGS_EN
  logic         zero, ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_n #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .c_i   (c_i),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .r_hi  (r_hi),
    .c_o   (c_o)
`ifdef ALU_STATUS_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs derived from arithmetic on the latched operands.
  logic [W-1:0]   m_r, m_hi, m_a, m_b;
  logic           m_co, m_done, m_busy, m_zero, m_ovf;
  logic [2*W-1:0] m_prod;
  longint         m_s;
  int             m_left = 0;
  bit             m_valid = 0;

  task automatic model_step();
    if (rst) begin
      m_r = '0; m_hi = '0; m_co = 0; m_done = 0; m_busy = 0; m_zero = 0; m_ovf = 0;
      m_left = 0; m_valid = 1;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_prod = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
          {m_hi, m_r} = m_prod;
          m_co = 0; m_done = 1; m_busy = 0; m_ovf = 0;
          m_zero = (m_prod == 0);
        end
      end else if (start) begin
        if (op == 3'b011) begin
          m_a = a; m_b = b; m_left = W; m_busy = 1;
        end else begin
          m_hi = '0; m_co = 0; m_ovf = 0; m_done = 1;
          case (op)
            3'b000: begin
              {m_co, m_r} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_i};
              m_s = longint'($signed(a)) + longint'($signed(b)) + longint'(c_i);
              m_ovf = (m_s > 64'sd2147483647) || (m_s < -64'sd2147483648);
            end
            3'b010: begin
              {m_co, m_r} = {1'b0, a} + {1'b0, ~b} + 33'd1;
              m_s = longint'($signed(a)) - longint'($signed(b));
              m_ovf = (m_s > 64'sd2147483647) || (m_s < -64'sd2147483648);
            end
            3'b001:  m_r = a ^ b;
            3'b100:  m_r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b101:  m_r = ~(a | b);
            3'b110:  m_r = a & b;
            default: m_r = a | b;
          endcase
          m_zero = (m_r == 0);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("cyc_done", done, m_done);
      check("cyc_busy", busy, m_busy);
      check("cyc_r", r, m_r);
      check("cyc_r_hi", r_hi, m_hi);
      check("cyc_c_o", c_o, m_co);
`ifdef ALU_STATUS_FLAGS_EN
      check("cyc_zero", zero, m_zero);
      check("cyc_ovf", ovf, m_ovf);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    start = 1'b1; op = o; a = x; b = y; c_i = ci;
    @(negedge clk);
    start = 1'b0;
  endtask

  int  lat;
  bit  seen;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_r", r, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b000, 32'hC3FF_0000, 32'h0000_FFFF, 1'b1);
    check("add_done", done, 1);
    check("add_r", r, 32'hC400_0000);
    check("add_c_o", c_o, 0);
    check("add_r_hi", r_hi, 0);
    @(negedge clk);
    check("add_done_drop", done, 0);

    issue(3'b010, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0);
    check("sub1_done", done, 1);
    check("sub1_r", r, 32'h0000_0008);
    check("sub1_c_o", c_o, 0);
    issue(3'b010, 32'h0000_0005, 32'h0000_0004, 1'b1);
    check("sub2_done", done, 1);
    check("sub2_r", r, 32'h0000_0001);
    check("sub2_c_o", c_o, 1);

    issue(3'b100, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0);
    check("slt1_r", r, 0);
    issue(3'b100, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 1'b0);
    check("slt2_r", r, 1);
    @(negedge clk);

    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mul_busy", busy, 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1; op = 3'b000; a = 32'h1; b = 32'h1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      check("mul_hold_r", r, 1);
    end
    start = 1'b0;
    check("mul_latency", lat, 32);
    check("mul_r_hi", r_hi, 32'hFFFF_FFFE);
    check("mul_r", r, 32'h0000_0001);
    check("mul_busy_end", busy, 0);
    // Issue in the done cycle: must be accepted.
    issue(3'b001, 32'hA5A5_0000, 32'hFFFF_0000, 1'b0);
    check("xor_after_mul_done", done, 1);
    check("xor_after_mul_r", r, 32'h5A5A_0000);
    check("xor_after_mul_r_hi", r_hi, 0);

    issue(3'b011, 32'h0000_1234, 32'h0000_5678, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_r", r, 0);
    check("abort_r_hi", r_hi, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("abort_no_done", seen, 0);
    issue(3'b000, 32'h5, 32'h9, 1'b0);
    check("add_after_abort", r, 32'h0000_000E);

    rst = 1'b1;
    issue(3'b000, 32'h1, 32'h1, 1'b0);
    rst = 1'b0;
    check("rst_start_done", done, 0);
    check("rst_start_r", r, 0);

    issue(3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0);
    check("wrap_r", r, 0);
    check("wrap_c_o", c_o, 1);
    issue(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    check("and_r", r, 32'hF000_F000);
    check("and_c_o", c_o, 0);
    issue(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    check("or_r", r, 32'hFFF0_FFF0);
    issue(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    check("nor_r", r, 32'h000F_000F);

    issue(3'b011, 32'h0001_0003, 32'h0002_0005, 1'b0);
    repeat (31) @(negedge clk);
    check("mul2_not_yet", done, 0);
    @(negedge clk);
    check("mul2_done", done, 1);
    check("mul2_r_hi", r_hi, 32'h0000_0002);
    check("mul2_r", r, 32'h000B_000F);

`ifdef ALU_STATUS_FLAGS_EN
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("flag_add_ovf", ovf, 1);
    check("flag_add_zero", zero, 0);
    issue(3'b001, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
    check("flag_xor_zero", zero, 1);
    check("flag_xor_ovf", ovf, 0);
    issue(3'b011, 32'h0, 32'hFF, 1'b0);
    repeat (32) @(negedge clk);
    check("flag_mul_zero", zero, 1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
